// File: rtl/mul16x16_seq_pkg.sv
// Shared definitions for the sequential 16x16 multiplier: widths, FSM encoding,
// step decoding and the small vedic building blocks used by the 8x8 core.
package mul16x16_seq_pkg;

    localparam int OPW   = 16;
    localparam int HALFW = 8;
    localparam int PW    = 32;
    localparam int PPW   = 2 * HALFW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Which operand halves feed the core on a given step.
    typedef struct packed {
        logic a_hi;
        logic b_hi;
    } half_sel_t;

    function automatic half_sel_t step_sel(input logic [1:0] step);
        half_sel_t s;
        s.a_hi = step[0];
        s.b_hi = step[1];
        return s;
    endfunction

    // Partial-product weight: 8 bits per high half taking part.
    function automatic logic [4:0] step_shift(input logic [1:0] step);
        logic [4:0] halves;
        halves = 5'(step[0]) + 5'(step[1]);
        return halves << 3;
    endfunction

    // 2x2 vedic cell: vertical and crosswise terms with a half-adder carry.
    function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
        logic c1;
        logic [3:0] r;
        r[0] = x[0] & y[0];
        r[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
        c1   = (x[1] & y[0]) & (x[0] & y[1]);
        r[2] = (x[1] & y[1]) ^ c1;
        r[3] = (x[1] & y[1]) & c1;
        return r;
    endfunction

    function automatic logic [7:0] vedic4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] q0, q1, q2, q3;
        q0 = vedic2(x[1:0], y[1:0]);
        q1 = vedic2(x[3:2], y[1:0]);
        q2 = vedic2(x[1:0], y[3:2]);
        q3 = vedic2(x[3:2], y[3:2]);
        return {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
    endfunction

endpackage

// File: rtl/mul16x16_seq_core.sv
// Combinational 8x8 unsigned vedic multiplier, built from four 4x4 vedic
// blocks whose products are recombined with their half-word weights.
module mul8x8
    import mul16x16_seq_pkg::*;
(
    input  logic [HALFW-1:0] a,
    input  logic [HALFW-1:0] b,
    output logic [PPW-1:0]   p
);

    logic [7:0] quad [4];

    // quad[0]=alo*blo, quad[1]=ahi*blo, quad[2]=alo*bhi, quad[3]=ahi*bhi
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_quad
            assign quad[gi] = vedic4(a[(gi % 2) * 4 +: 4], b[(gi / 2) * 4 +: 4]);
        end
    endgenerate

    assign p = {8'b0, quad[0]}
             + {4'b0, quad[1], 4'b0}
             + {4'b0, quad[2], 4'b0}
             + {quad[3], 8'b0};

endmodule

// File: rtl/mul16x16_seq.sv
// Sequential 16x16 unsigned multiplier: one shared 8x8 core is stepped over
// the four half-word pairs and the shifted partial products are accumulated.
module mul16x16_seq
    import mul16x16_seq_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [PW-1:0]  p,
    output logic           busy
);

    state_t         state_reg, state_next;
    logic [1:0]     step_reg, step_next;
    logic [OPW-1:0] a_reg, a_next;
    logic [OPW-1:0] b_reg, b_next;
    logic [PW-1:0]  acc_reg, acc_next;

    half_sel_t        sel;
    logic [HALFW-1:0] core_a, core_b;
    logic [PPW-1:0]   pp;
    logic [PW-1:0]    pp_shifted;

    always_comb begin
        sel        = step_sel(step_reg);
        core_a     = sel.a_hi ? a_reg[OPW-1:HALFW] : a_reg[HALFW-1:0];
        core_b     = sel.b_hi ? b_reg[OPW-1:HALFW] : b_reg[HALFW-1:0];
        pp_shifted = {{(PW - PPW){1'b0}}, pp} << step_shift(step_reg);
    end

    mul8x8 u_core (
        .a (core_a),
        .b (core_b),
        .p (pp)
    );

    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        acc_next   = acc_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;

        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase

        // Abort wins over every transition, including a same-cycle accept.
        if (clear) begin
            state_next = IDLE;
            step_next  = 2'd0;
            acc_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_next     = a;
                        b_next     = b;
                        acc_next   = '0;
                        step_next  = 2'd0;
                        state_next = MUL;
                    end
                end
                MUL: begin
                    acc_next  = acc_reg + pp_shifted;
                    step_next = step_reg + 2'd1;
                    if (step_reg == 2'd3) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            step_reg  <= 2'd0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            acc_reg   <= acc_next;
        end
    end

    assign p = acc_reg;

endmodule
